ddr_axi_tester: RTL
===================

# ddr_axi_tester

AXI-style burst initiator that drives the user port of `ddr_sdram_ctrl` (write-address/write-data/write-response and read-address/read-data channels) for bring-up and soak testing. It writes a deterministic pattern over a configurable region in fixed-length bursts, reads the region back, compares every beat, and reports pass/fail and an error count. It sits in the `core_clk` domain next to the controller and is the only master on that port when instantiated.

## Interface
- `BA_BITS`, default 2: bank address bits, same value as the controller.
- `ROW_BITS`, default 13: row address bits.
- `COL_BITS`, default 11: column address bits.
- `DQ_LEVEL`, default 1: data width selector; AXI data width is DW = 8<<DQ_LEVEL and address width is AW = BA_BITS+ROW_BITS+COL_BITS+DQ_LEVEL-1.
- `BURST_LEN`, default 127: value driven on `awlen`/`arlen`, giving BURST_LEN+1 beats per burst.
- `NUM_BURSTS`, default 16: bursts per pass, range 1..65535.
- `BASE_ADDR`, default 0: byte address of the first burst.
- `core_clk` in, 1: clock.
- `core_rstn_sync` in, 1: reset, asynchronous and active-low.
- `start` in, 1: level; begins a pass when it is high in IDLE.
- `busy` out, 1: high in any state except IDLE and DONE.
- `done` out, 1: high in DONE.
- `error` out, 1: sticky; set on any mismatch or rlast violation in the current run.
- `error_count` out, 16: saturating count of bad beats.
- AXI channels, connected one-to-one to the controller: `awvalid`, `awready`, `awaddr`[AW], `awlen`[8], `wvalid`, `wready`, `wlast`, `wdata`[DW], `bvalid`, `bready`, `arvalid`, `arready`, `araddr`[AW], `arlen`[8], `rvalid`, `rready`, `rlast`, `rdata`[DW]. Directions are mirrored from the controller.

## Operation
- States and transitions:
  - IDLE → AW on `start`.
  - AW → W on `awvalid&&awready`.
  - W → B on the last beat accepted.
  - B → AW when `bvalid` is seen and bursts remain; B → AR when `bvalid` is seen on the last burst.
  - AR → R on `arvalid&&arready`.
  - R → AR when the last beat is received and bursts remain; R → DONE on the last beat of the last burst.
  - DONE → IDLE when `start` is low.
- Burst address:
  - awaddr = araddr = BASE_ADDR + burst_idx*((BURST_LEN+1)<<DQ_LEVEL). This is a byte address, truncated to AW bits, so it wraps modulo 2^AW.
  - The write burst counter and the read burst counter are separate and each is reset when its phase starts.
- Pattern:
  - Word index i = burst_idx*(BURST_LEN+1)+beat.
  - wdata = i zero-extended or truncated to DW.
  - The expected value on read uses the same formula.
- Write channel:
  - `wvalid` is high for the whole W state.
  - `wdata`/`wlast` advance only on `wvalid&&wready`.
  - `wlast` is high when beat==BURST_LEN.
- `bready`=1 in B and 0 otherwise.
- Read channel:
  - `rready`=1 in R and 0 otherwise.
  - Each accepted beat is compared with the expected value.
  - `rlast` must be 1 exactly when beat==BURST_LEN.
  - A data mismatch or an rlast mismatch counts as one bad beat; both on the same beat still count as one.
  - If rlast arrives early, the burst is closed at that beat (the burst counter advances).
- `error_count` saturates at 0xFFFF. `error` and `error_count` clear on the IDLE→AW transition.
- `start` is sampled only in IDLE and DONE. Dropping it mid-pass has no effect.

## Timing
- Reset values:
  - All valid/ready outputs, `busy`, `done`, `error` = 0.
  - `error_count`, `awaddr`, `araddr`, `wdata` = 0.
  - `wlast` = 0.
  - `awlen`/`arlen` are constant BURST_LEN.
- Reset assertion mid-transaction forces the reset values asynchronously. The controller must be reset in the same event.
- `awvalid`/`arvalid` assert on the first cycle in AW/AR and hold with a stable address until the handshake.
- `wvalid` is first high in the cycle after the AW handshake.
- Comparison is registered: `error`/`error_count` update one cycle after the offending beat.
- `done` rises one cycle after the final R beat, including the cycle needed for a final error update.
- All outputs are registered; no combinational path from any ready/valid input to an output.

## Configuration
- `DDR_TESTER_LOOP_EN` defined: on reaching the end of a read pass with `start` still high, the block goes to AW instead of DONE. It starts another pass with the pattern inverted (~i) on alternate passes. `error`/`error_count` accumulate across passes and clear only on IDLE→AW.
- Undefined: a single pass, then DONE.

## Structure
- The shared define/config include holds:
  - the AW and DW width macros derived from BA_BITS/ROW_BITS/COL_BITS/DQ_LEVEL;
  - the state encoding localparams.
- One sub-module, `ddr_tester_pattern`, maps (burst_idx, beat, pass parity) to a DW-bit word. It is instantiated twice, once for write and once for expected read data.

## Test plan
- Reset asserted mid-stream → all outputs 0, `error_count`=0. After release, IDLE holds until `start`.
- DQ_LEVEL=1, BURST_LEN=3, NUM_BURSTS=2, ideal memory slave:
  - awaddr is 0 then 8, and wdata is 0..7;
  - araddr is 0 then 8, with reads matching;
  - result: `done`=1, `error`=0, `error_count`=0.
- Same setup, slave flips bit 0 of read beat 5 → `error`=1, `error_count`=1, `done`=1.
- `awready` delayed 10 cycles and `wready` toggling each cycle → wdata seen at handshakes is exactly 0,1,2,3 per burst, with no duplicates or skips.
- Slave asserts `rlast` on beat 1 of burst 0 → `error_count`=1, burst 1 reads at araddr 8, then DONE.
- With `DDR_TESTER_LOOP_EN` and `start` held high:
  - the second pass writes ~0 … ~7 (0xFFFF, 0xFFFE, …);
  - `done` stays 0;
  - `error_count` stays 0 with an ideal slave.

Source files
------------

// File: rtl/ddr_axi_tester_pkg.sv
// Shared types and width helpers for the DDR AXI burst tester.
// Optional looping soak mode is selected by defining DDR_TESTER_LOOP_EN.
package ddr_axi_tester_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StB,
    StAr,
    StR,
    StDone
  } state_e;

  localparam logic [15:0] CountMax = 16'hFFFF;

  // Byte address width of the controller user port.
  function automatic int unsigned axi_aw(input int unsigned ba_bits, input int unsigned row_bits,
                                         input int unsigned col_bits, input int unsigned dq_level);
    return ba_bits + row_bits + col_bits + dq_level - 1;
  endfunction

  function automatic int unsigned axi_dw(input int unsigned dq_level);
    return 8 << dq_level;
  endfunction

endpackage

// File: rtl/ddr_axi_tester_if.sv
// AXI-style user port between the tester (master) and ddr_sdram_ctrl (slave).
interface ddr_axi_tester_if #(
  parameter int unsigned AW = 26,
  parameter int unsigned DW = 16
);
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic          wvalid;
  logic          wready;
  logic          wlast;
  logic [DW-1:0] wdata;
  logic          bvalid;
  logic          bready;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic          rvalid;
  logic          rready;
  logic          rlast;
  logic [DW-1:0] rdata;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
    output arvalid, araddr, arlen, rready,
    input  awready, wready, bvalid, arready, rvalid, rlast, rdata
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
    input  arvalid, araddr, arlen, rready,
    output awready, wready, bvalid, arready, rvalid, rlast, rdata
  );
endinterface

// File: rtl/ddr_tester_pattern.sv
// Test pattern: word index burst_idx*(BURST_LEN+1)+beat, truncated to DW and
// optionally inverted for odd passes.
module ddr_tester_pattern #(
  parameter int unsigned DW        = 16,
  parameter int unsigned BURST_LEN = 127
) (
  input  logic [15:0]   burst_idx,
  input  logic [7:0]    beat,
  input  logic          invert,
  output logic [DW-1:0] word
);
  logic [31:0] idx;

  assign idx  = 32'(burst_idx) * 32'(BURST_LEN + 1) + 32'(beat);
  assign word = invert ? ~DW'(idx) : DW'(idx);
endmodule

// File: rtl/ddr_axi_tester.sv
// Burst write/read-back tester for the ddr_sdram_ctrl user port.
// Define DDR_TESTER_LOOP_EN to repeat passes (alternately inverted) while start stays high.
module ddr_axi_tester
  import ddr_axi_tester_pkg::*;
#(
  parameter int unsigned BA_BITS    = 2,
  parameter int unsigned ROW_BITS   = 13,
  parameter int unsigned COL_BITS   = 11,
  parameter int unsigned DQ_LEVEL   = 1,
  parameter int unsigned BURST_LEN  = 127,
  parameter int unsigned NUM_BURSTS = 16,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic             core_clk,
  input  logic             core_rstn_sync,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [15:0]      error_count,
  ddr_axi_tester_if.master axi
);
  localparam int unsigned AW         = axi_aw(BA_BITS, ROW_BITS, COL_BITS, DQ_LEVEL);
  localparam int unsigned DW         = axi_dw(DQ_LEVEL);
  localparam int unsigned BurstBytes = (BURST_LEN + 1) << DQ_LEVEL;
  localparam logic [7:0]  LastBeat   = 8'(BURST_LEN);
  localparam logic [15:0] LastBurst  = 16'(NUM_BURSTS - 1);

  // Byte address wraps modulo 2^AW.
  function automatic logic [AW-1:0] burst_addr(input logic [15:0] idx);
    return AW'(BASE_ADDR) + AW'(idx) * AW'(BurstBytes);
  endfunction

  state_e        state_q, state_d;
  logic [15:0]   wburst_q, wburst_d, rburst_q, rburst_d;
  logic [7:0]    wbeat_q, wbeat_d, rbeat_q, rbeat_d;
  logic          pass_q, pass_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [DW-1:0] wdata_q, wpat, rpat;
  logic          wlast_q;
  logic [AW-1:0] awaddr_q, araddr_q;
  logic          r_bad, r_close;

  // Write data is looked up for the beat about to be presented, then registered.
  ddr_tester_pattern #(
    .DW       (DW),
    .BURST_LEN(BURST_LEN)
  ) u_wpat (
    .burst_idx(wburst_d),
    .beat     (wbeat_d),
    .invert   (pass_d),
    .word     (wpat)
  );

  ddr_tester_pattern #(
    .DW       (DW),
    .BURST_LEN(BURST_LEN)
  ) u_rpat (
    .burst_idx(rburst_q),
    .beat     (rbeat_q),
    .invert   (pass_q),
    .word     (rpat)
  );

  always_comb begin
    state_d  = state_q;
    wburst_d = wburst_q;
    wbeat_d  = wbeat_q;
    rburst_d = rburst_q;
    rbeat_d  = rbeat_q;
    pass_d   = pass_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    // A data and an rlast mismatch on the same beat count once.
    r_bad    = (axi.rdata != rpat) || (axi.rlast != (rbeat_q == LastBeat));
    r_close  = axi.rlast || (rbeat_q == LastBeat);

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StAw;
          wburst_d = '0;
          wbeat_d  = '0;
          pass_d   = 1'b0;
          err_d    = 1'b0;
          cnt_d    = '0;
        end
      end
      StAw: begin
        if (axi.awready) begin
          state_d = StW;
          wbeat_d = '0;
        end
      end
      StW: begin
        if (axi.wready) begin
          if (wbeat_q == LastBeat) begin
            state_d = StB;
          end else begin
            wbeat_d = wbeat_q + 8'd1;
          end
        end
      end
      StB: begin
        if (axi.bvalid) begin
          if (wburst_q == LastBurst) begin
            state_d  = StAr;
            rburst_d = '0;
            rbeat_d  = '0;
          end else begin
            state_d  = StAw;
            wburst_d = wburst_q + 16'd1;
          end
        end
      end
      StAr: begin
        if (axi.arready) begin
          state_d = StR;
          rbeat_d = '0;
        end
      end
      StR: begin
        if (axi.rvalid) begin
          if (r_bad) begin
            err_d = 1'b1;
            if (cnt_q != CountMax) begin
              cnt_d = cnt_q + 16'd1;
            end
          end
          if (r_close) begin
            rbeat_d = '0;
            if (rburst_q == LastBurst) begin
`ifdef DDR_TESTER_LOOP_EN
              if (start) begin
                state_d  = StAw;
                wburst_d = '0;
                wbeat_d  = '0;
                pass_d   = ~pass_q;
              end else begin
                state_d = StDone;
              end
`else
              state_d = StDone;
`endif
            end else begin
              state_d  = StAr;
              rburst_d = rburst_q + 16'd1;
            end
          end else begin
            rbeat_d = rbeat_q + 8'd1;
          end
        end
      end
      StDone: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rstn_sync) begin
    if (!core_rstn_sync) begin
      state_q  <= StIdle;
      wburst_q <= '0;
      wbeat_q  <= '0;
      rburst_q <= '0;
      rbeat_q  <= '0;
      pass_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      wlast_q  <= 1'b0;
      awaddr_q <= '0;
      araddr_q <= '0;
    end else begin
      state_q  <= state_d;
      wburst_q <= wburst_d;
      wbeat_q  <= wbeat_d;
      rburst_q <= rburst_d;
      rbeat_q  <= rbeat_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      wlast_q  <= (state_d == StW) && (wbeat_d == LastBeat);
      if (state_d == StW) begin
        wdata_q <= wpat;
      end
      if (state_d == StAw) begin
        awaddr_q <= burst_addr(wburst_d);
      end
      if (state_d == StAr) begin
        araddr_q <= burst_addr(rburst_d);
      end
    end
  end

  assign axi.awvalid = (state_q == StAw);
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = 8'(BURST_LEN);
  assign axi.wvalid  = (state_q == StW);
  assign axi.wdata   = wdata_q;
  assign axi.wlast   = wlast_q;
  assign axi.bready  = (state_q == StB);
  assign axi.arvalid = (state_q == StAr);
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 8'(BURST_LEN);
  assign axi.rready  = (state_q == StR);

  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign done        = (state_q == StDone);
  assign error       = err_q;
  assign error_count = cnt_q;
endmodule
